// File: rtl/i2c_message_buffer_if.sv
// i2c_message_buffer_if
//   Bundles the host write port and the transmitter-facing read/control
//   signals of the I2C message buffer.
//   Host side     : wr_data, wr_valid, wr_ready, flush
//   Transmitter   : index_bit/msg/trans, tx_done, msg_bit, start, busy
//   Constants     : limit_bit/msg/trans (driven by the buffer)
//   slave  modport: the buffer itself
//   master modport: whoever drives the buffer (host + transmitter)
interface i2c_message_buffer_if #(
   parameter int BI_BW = 3,
   parameter int MI_BW = 2,
   parameter int TI_BW = 5
);
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic             flush;
   logic [BI_BW-1:0] index_bit;
   logic [MI_BW-1:0] index_msg;
   logic [TI_BW-1:0] index_trans;
   logic             tx_done;
   logic             msg_bit;
   logic             start;
   logic             busy;
   logic [BI_BW-1:0] limit_bit;
   logic [MI_BW-1:0] limit_msg;
   logic [TI_BW-1:0] limit_trans;

   modport slave (
      input  wr_data, wr_valid, flush, index_bit, index_msg, index_trans, tx_done,
      output wr_ready, msg_bit, start, busy, limit_bit, limit_msg, limit_trans
   );

   modport master (
      output wr_data, wr_valid, flush, index_bit, index_msg, index_trans, tx_done,
      input  wr_ready, msg_bit, start, busy, limit_bit, limit_msg, limit_trans
   );
endinterface

// File: rtl/i2c_message_buffer.sv
// i2c_message_buffer
//   Staging buffer for one full I2C transfer set: (LIMIT_TRANS+1)
//   transactions of (LIMIT_MSG+1) bytes. The host fills it over a
//   valid/ready port; once full, the buffer pulses start, then serves
//   msg_bit from the transmitter's indices until tx_done.
//   Ports:
//     clock  - rising-edge clock
//     reset  - asynchronous active-high reset
//     bus    - i2c_message_buffer_if.slave (write port, read indices,
//              start/busy/tx_done handshake, limit constants)
module i2c_message_buffer #(
   parameter int BI_BW       = 3,
   parameter int MI_BW       = 2,
   parameter int TI_BW       = 5,
   parameter int LIMIT_BIT   = 7,
   parameter int LIMIT_MSG   = 2,
   parameter int LIMIT_TRANS = 31
) (
   input logic                  clock,
   input logic                  reset,
   i2c_message_buffer_if.slave  bus
);

   if (LIMIT_MSG >= (1 << MI_BW)) begin : g_bad_msg
      $error("LIMIT_MSG does not fit in MI_BW bits");
   end
   if (LIMIT_TRANS >= (1 << TI_BW)) begin : g_bad_trans
      $error("LIMIT_TRANS does not fit in TI_BW bits");
   end
   if (LIMIT_BIT >= (1 << BI_BW)) begin : g_bad_bit
      $error("LIMIT_BIT does not fit in BI_BW bits");
   end

   typedef enum logic [1:0] {LOAD, ARM, SEND} state_t;

   state_t           state, state_nxt;
   logic [MI_BW-1:0] wr_msg;
   logic [TI_BW-1:0] wr_trans;
   logic [7:0]       mem [LIMIT_TRANS+1][LIMIT_MSG+1];
   logic             wr_ready, start, busy, msg_bit_q;

   // Flush only counts in LOAD and overrides a same-cycle write.
   logic accept, flush_ld, store, msg_last, trans_last, clear_cnt;
   assign accept     = bus.wr_valid && (state == LOAD);
   assign flush_ld   = bus.flush && (state == LOAD);
   assign store      = accept && !flush_ld;
   assign msg_last   = (wr_msg == MI_BW'(LIMIT_MSG));
   assign trans_last = (wr_trans == TI_BW'(LIMIT_TRANS));
   assign clear_cnt  = flush_ld || ((state == SEND) && bus.tx_done);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      start     = 1'b0;
      busy      = 1'b0;
      case (state)
         LOAD: begin
            wr_ready = 1'b1;
            if (store && msg_last && trans_last) state_nxt = ARM;
         end
         ARM: begin
            start     = 1'b1;
            busy      = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            busy = 1'b1;
            if (bus.tx_done) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_msg   <= '0;
         wr_trans <= '0;
      end else if (clear_cnt) begin
         wr_msg   <= '0;
         wr_trans <= '0;
      end else if (store) begin
         if (msg_last) begin
            wr_msg   <= '0;
            wr_trans <= trans_last ? '0 : wr_trans + 1'b1;
         end else begin
            wr_msg <= wr_msg + 1'b1;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (store) mem[wr_trans][wr_msg] <= bus.wr_data;
   end

   // Read path: bit 0 of the index is the MSB of the byte on the wire.
   logic             rd_in_range;
   logic [BI_BW-1:0] bit_sel;
   logic [7:0]       rd_byte;
   assign rd_in_range = (int'(bus.index_msg) <= LIMIT_MSG) &&
                        (int'(bus.index_trans) <= LIMIT_TRANS);
   assign bit_sel     = BI_BW'(LIMIT_BIT) - bus.index_bit;

   always_comb begin
      rd_byte = 8'h00;
      if (rd_in_range) rd_byte = mem[bus.index_trans][bus.index_msg];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) msg_bit_q <= 1'b0;
      else       msg_bit_q <= rd_in_range ? rd_byte[bit_sel] : 1'b0;
   end

   assign bus.wr_ready    = wr_ready;
   assign bus.start       = start;
   assign bus.busy        = busy;
   assign bus.msg_bit     = msg_bit_q;
   assign bus.limit_bit   = BI_BW'(LIMIT_BIT);
   assign bus.limit_msg   = MI_BW'(LIMIT_MSG);
   assign bus.limit_trans = TI_BW'(LIMIT_TRANS);

endmodule

// File: tb/tb_i2c_message_buffer.sv
module tb_i2c_message_buffer;
   localparam int LB = 7;
   localparam int LM = 2;
   localparam int LT = 31;
   localparam int NBYTES = (LM + 1) * (LT + 1);

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n_start = 0;

   i2c_message_buffer_if #(.BI_BW(3), .MI_BW(2), .TI_BW(5)) bus ();

   i2c_message_buffer #(
      .BI_BW(3), .MI_BW(2), .TI_BW(5),
      .LIMIT_BIT(LB), .LIMIT_MSG(LM), .LIMIT_TRANS(LT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: linear byte store plus a three-phase view of the set.
   int mmem [NBYTES];
   bit mvld [NBYTES];
   int phase = 0;       // 0 loading, 1 launching, 2 transmitting
   int n = 0;           // bytes accepted into the current set
   int e_bit = 0;
   bit e_known = 1'b1;
   int m_a;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         phase = 0; n = 0; e_bit = 0; e_known = 1'b1;
      end else begin
         if (int'(bus.index_msg) > LM || int'(bus.index_trans) > LT) begin
            e_bit = 0; e_known = 1'b1;
         end else begin
            m_a = int'(bus.index_trans) * (LM + 1) + int'(bus.index_msg);
            e_known = mvld[m_a];
            e_bit = (mmem[m_a] >> (LB - int'(bus.index_bit))) & 1;
         end
         case (phase)
            0: if (bus.flush) n = 0;
               else if (bus.wr_valid) begin
                  mmem[n] = int'(bus.wr_data);
                  mvld[n] = 1'b1;
                  n++;
                  if (n == NBYTES) begin n = 0; phase = 1; end
               end
            1: phase = 2;
            default: if (bus.tx_done) begin phase = 0; n = 0; end
         endcase
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         chk("cyc_wr_ready", int'(bus.wr_ready), int'(phase == 0));
         chk("cyc_start", int'(bus.start), int'(phase == 1));
         chk("cyc_busy", int'(bus.busy), int'(phase != 0));
         chk("cyc_limit_bit", int'(bus.limit_bit), LB);
         chk("cyc_limit_msg", int'(bus.limit_msg), LM);
         chk("cyc_limit_trans", int'(bus.limit_trans), LT);
         if (e_known) chk("cyc_msg_bit", int'(bus.msg_bit), e_bit);
         if (bus.start) n_start++;
      end
   end

   // Drive wr_data until accepted; leaves wr_valid high for back-to-back use.
   task automatic push(input logic [7:0] d);
      bit ok = 1'b0;
      bit rdy;
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      for (int c = 0; c < 20 && !ok; c++) begin
         rdy = bus.wr_ready;
         @(posedge clock); #1;
         if (rdy) ok = 1'b1;
      end
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic load(input int base, input int cnt);
      for (int k = 0; k < cnt; k++) push(8'((base + k) & 255));
      bus.wr_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic rd(input int t, input int m, input int b, output int v);
      bus.index_trans = 5'(t);
      bus.index_msg   = 2'(m);
      bus.index_bit   = 3'(b);
      tick();
      v = int'(bus.msg_bit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int v;
      bus.wr_data = 8'h00; bus.wr_valid = 1'b0; bus.flush = 1'b0; bus.tx_done = 1'b0;
      bus.index_bit = '0; bus.index_msg = '0; bus.index_trans = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_wr_ready", int'(bus.wr_ready), 1);
      chk("rst_start", int'(bus.start), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_msg_bit", int'(bus.msg_bit), 0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      repeat (20) tick();
      chk("idle_no_start", n_start, 0);

      // full load, byte k = k
      load(0, NBYTES);
      chk("full_ready_low", int'(bus.wr_ready), 0);
      chk("full_start", int'(bus.start), 1);
      chk("full_busy", int'(bus.busy), 1);
      tick();
      chk("send_start_low", int'(bus.start), 0);
      chk("start_once", n_start, 1);
      rd(5, 1, 0, v);  chk("rd_t5_m1_b0", v, 0);
      rd(31, 2, 7, v); chk("rd_t31_m2_b7", v, 1);
      rd(31, 2, 0, v); chk("rd_t31_m2_b0", v, 0);
      rd(31, 2, 3, v); chk("rd_t31_m2_b3", v, 1);
      rd(0, 1, 7, v);  chk("rd_t0_m1_b7", v, 1);
      rd(10, 3, 0, v); chk("rd_msg_oob", v, 0);

      // ignored events in SEND
      bus.wr_valid = 1'b1; bus.wr_data = 8'hEE; bus.flush = 1'b1;
      tick();
      chk("flush_in_send_busy", int'(bus.busy), 1);
      bus.flush = 1'b0;
      tick(); tick();
      bus.wr_valid = 1'b0;
      rd(0, 0, 0, v); chk("send_write_ignored", v, 0);

      bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
      chk("done_busy", int'(bus.busy), 0);
      chk("done_ready", int'(bus.wr_ready), 1);

      bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;
      chk("load_txdone_ready", int'(bus.wr_ready), 1);
      chk("load_txdone_busy", int'(bus.busy), 0);

      // flush coincident with a write drops the byte
      bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
      tick();
      bus.flush = 1'b0; bus.wr_valid = 1'b0;
      rd(0, 0, 0, v); chk("flush_drops_byte", v, 0);

      // partial load, flush, then a full set is still required
      load(8'h80, 10);
      bus.flush = 1'b1; tick(); bus.flush = 1'b0;
      load(8'h80, NBYTES - 1);
      tick();
      chk("no_start_95", n_start, 1);
      push(8'hDF);
      bus.wr_valid = 1'b0;
      chk("reload_start", int'(bus.start), 1);
      tick();
      chk("start_twice", n_start, 2);
      rd(0, 0, 0, v);  chk("reload_from_0", v, 1);
      rd(31, 2, 0, v); chk("reload_last", v, 1);
      bus.tx_done = 1'b1; tick(); bus.tx_done = 1'b0;

      // reset during SEND
      load(0, NBYTES);
      tick();
      #1 reset = 1'b1;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_ready", int'(bus.wr_ready), 1);
      chk("midrst_start", int'(bus.start), 0);
      chk("midrst_msg_bit", int'(bus.msg_bit), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      chk("midrst_starts", n_start, 3);
      load(0, NBYTES - 1);
      tick();
      chk("midrst_no_start_95", n_start, 3);
      push(8'd95);
      bus.wr_valid = 1'b0;
      tick();
      chk("midrst_reload_start", n_start, 4);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_message_buffer.md
# i2c_message_buffer

Byte-wide staging buffer that sits directly upstream of the I2C master transmitter and fills its message-ROM slot. A host pushes a complete transfer set, (LIMIT_TRANS+1) transactions of (LIMIT_MSG+1) bytes each, over a valid/ready port. The buffer then pulses `start` to the transmitter sequencer and serves `msg_bit` from the bit/message/transaction indices until the transmitter reports completion. It also drives the `LIMIT_*` constants consumed by the message controller FSM.

## Interface
- BI_BW, 3, bit-index width
- MI_BW, 2, message-index width
- TI_BW, 5, transaction-index width
- LIMIT_BIT, 7, last bit index per byte (8-bit bytes)
- LIMIT_MSG, 2, last message index (3 bytes per transaction: address, register, data)
- LIMIT_TRANS, 31, last transaction index
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_data  in  8  byte from host
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  buffer accepts a byte this cycle
- flush  in  1  discard a partially loaded set (honoured in LOAD only)
- index_bit  in  BI_BW  current bit; 0 = MSB
- index_msg  in  MI_BW  current byte within the transaction
- index_trans  in  TI_BW  current transaction
- tx_done  in  1  one-cycle pulse from the transmitter after the stop of the final transaction
- msg_bit  out  1  registered bit for the master FSM
- start  out  1  one-cycle launch pulse to the transmitter sequencer
- busy  out  1  high in ARM and SEND
- limit_bit / limit_msg / limit_trans  out  BI_BW / MI_BW / TI_BW  constant copies of the parameters

## Operation
- Storage: (LIMIT_TRANS+1) × (LIMIT_MSG+1) bytes, addressed {trans, msg}. Storage is not reset.
- Write counters `wr_msg` and `wr_trans` reset to 0.
  - Each accepted byte is stored at {wr_trans, wr_msg}.
  - `wr_msg` increments and wraps to 0 after LIMIT_MSG.
  - `wr_trans` increments on that wrap.
- FSM states:
  - LOAD (reset state): `wr_ready`=1. Accepting the byte at {LIMIT_TRANS, LIMIT_MSG} moves to ARM.
  - ARM: `start`=1 for exactly this one cycle, then go to SEND.
  - SEND: `wr_ready`=0. On `tx_done`, clear both write counters and return to LOAD.
- `flush` in LOAD clears both write counters; previously stored bytes stay but will be overwritten.
- `flush` together with an accepted write: flush wins and the byte is dropped (counters go to 0, storage unchanged).
- `flush` in ARM/SEND is ignored.
- `tx_done` outside SEND is ignored.
- `wr_valid` while `wr_ready`=0 has no effect. The host must hold `wr_data` until accepted.
- Read path, every cycle: `msg_bit` <= byte[{index_trans, index_msg}] bit (LIMIT_BIT − index_bit).
  - If index_msg > LIMIT_MSG or index_trans > LIMIT_TRANS, `msg_bit` <= 0.
  - The read path is active in all states.
- Width rules:
  - Counter compares are against the parameters, not the full counter range.
  - LIMIT_MSG < 2^MI_BW, LIMIT_TRANS < 2^TI_BW and LIMIT_BIT < 2^BI_BW are required; elaboration fails otherwise.

## Timing
- Reset values:
  - state LOAD, `wr_ready`=1, `start`=0, `busy`=0, `msg_bit`=0
  - counters 0, `limit_*` = parameters
- Write handshake: a byte is accepted on the rising edge where `wr_valid`&&`wr_ready`. Back-to-back acceptance is one byte per cycle.
- Load-complete edge (cycle N): `wr_ready` falls in cycle N+1. `start`=1 and `busy`=1 in N+1; SEND from N+2 (`start` back to 0).
- The final byte is readable through `msg_bit` from cycle N+1 (one-cycle read latency).
- `msg_bit` latency: one clock from an index change to the updated bit.
- `tx_done` at cycle M in SEND: `busy`=0 and `wr_ready`=1 from M+1.
- Reset asserted mid-operation (any state):
  - state returns to LOAD and all outputs take their reset values immediately (asynchronous);
  - an in-flight set is abandoned and the host must reload it completely.

## Test plan
- Reset then idle: `wr_ready`=1, `start`=0, `busy`=0, `msg_bit`=0. Release reset; hold `wr_valid`=0 for 20 cycles → no `start`.
- Full load, defaults:
  - Push 96 bytes (byte k = k[7:0]) back-to-back → `start` exactly once, one cycle after the 96th acceptance.
  - `wr_ready`=0 from the cycle after the last acceptance.
  - Index (trans 5, msg 1, bit 0) → `msg_bit`=byte 16 MSB=0 one cycle later. Index (trans 31, msg 2, bit 7) → byte 95 LSB=1.
- Completion:
  - In SEND, pulse `tx_done` → `busy`=0 and `wr_ready`=1 next cycle.
  - A new 96-byte load writes from {0,0} and `start` pulses again.
- Flush:
  - Load 10 bytes, pulse `flush` → counters 0. Then 96 more bytes are needed for `start`.
  - `flush` coincident with an accepted byte 0xA5 → the byte is not stored (its location keeps its prior value).
- Ignored events: `tx_done` in LOAD → no change; `flush` in SEND → `busy` stays 1; `wr_valid`=1 in SEND → storage unchanged.
- Mid-operation reset: assert reset in SEND → `busy`=0, `wr_ready`=1 asynchronously; after release, `start` needs a full 96-byte reload.
